mmu_stream_controller: RTL and testbench

Parametrised successor to the matrix multiply unit controller. Accepts MMU instructions into an internal queue and issues them back-to-back with no bubble. Streams buffer reads into the systolic data setup, then drives accumulator writes, each delayed to match the datapath latency. Sits between the instruction decoder and the unified buffer / systolic data setup / MMU / accumulator path.

---
 rtl/mmu_stream_controller.sv | 195 +++++++++++++++++++
 tb/tb_mmu_stream_controller.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_stream_controller.sv
// Queued MMU instruction issuer feeding buffer-read, MMU and accumulator delay lines.
// Optional performance counters are compiled in with `define MMU_CTRL_PERF_CNT_EN.
module mmu_stream_controller #(
  parameter int MATRIX_WIDTH      = 14,
  parameter int BUF_READ_LATENCY  = 1,
  parameter int MMU_EXTRA_LATENCY = 2,
  parameter int INSTR_QUEUE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  // instr = {opcode[63:56], length[55:40], acc_addr[39:24], buffer_addr[23:0]}
  input  logic [63:0] instr,
  input  logic        instr_enable,
  output logic        instr_ready,
  output logic [23:0] buffer_to_sds_addr,
  output logic        buffer_read_enable,
  output logic        mmu_sds_enable,
  output logic        is_mmu_signed,
  output logic        activate_weight,
  output logic [15:0] acc_addr,
  output logic        accumulate,
  output logic        acc_enable,
  output logic        busy,
  output logic        resource_busy,
  output logic        overflow
`ifdef MMU_CTRL_PERF_CNT_EN
  ,
  input  logic        perf_clear,
  output logic [31:0] rows_issued,
  output logic [31:0] stall_cycles
`endif
);

  localparam int QAW      = $clog2(INSTR_QUEUE_DEPTH);
  localparam int MMU_TAP  = BUF_READ_LATENCY - 1;
  localparam int LINE_LEN = BUF_READ_LATENCY + MATRIX_WIDTH + MMU_EXTRA_LATENCY;

  typedef enum logic {IDLE, ISSUE} state_t;

  logic [57:0]  queue_mem [INSTR_QUEUE_DEPTH];
  logic [QAW:0] wr_ptr_reg, rd_ptr_reg;
  logic         queue_empty, queue_full, push, pop, load, issue, last_row;
  logic [57:0]  head;
  logic [15:0]  head_len;
  logic         unused_opcode_bits;

  state_t       state_reg, state_next;
  logic [15:0]  row_reg, len_reg, acc_base_reg;
  logic [23:0]  buf_base_reg;
  logic         signed_reg, accum_reg, overflow_reg;

  logic [LINE_LEN-1:0] line_valid_reg, line_first_reg, line_signed_reg, line_accum_reg;
  logic [15:0]         line_addr_reg [LINE_LEN];

  assign unused_opcode_bits = ^instr[63:58];

  assign queue_empty = (wr_ptr_reg == rd_ptr_reg);
  assign queue_full  = (wr_ptr_reg[QAW] != rd_ptr_reg[QAW]) &&
                       (wr_ptr_reg[QAW-1:0] == rd_ptr_reg[QAW-1:0]);
  assign head        = queue_mem[rd_ptr_reg[QAW-1:0]];
  assign head_len    = head[55:40];
  // A pop in the same cycle frees a slot, so a full queue can still accept.
  assign instr_ready = !queue_full || pop;
  assign push        = instr_enable && instr_ready;

  always_ff @(posedge clk) begin
    if (push) queue_mem[wr_ptr_reg[QAW-1:0]] <= instr[57:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (instr_enable && !instr_ready) overflow_reg <= 1'b1;
    end
  end

  assign issue    = (state_reg == ISSUE) && enable;
  assign last_row = (row_reg == len_reg - 16'd1);

  // Zero-length heads are discarded while a row is issuing so they cost no cycle.
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    load       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (enable && !queue_empty) begin
          pop = 1'b1;
          if (head_len != 16'd0) begin
            load       = 1'b1;
            state_next = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (enable) begin
          if (last_row) begin
            if (!queue_empty) begin
              pop = 1'b1;
              if (head_len != 16'd0) load = 1'b1;
              else state_next = IDLE;
            end else begin
              state_next = IDLE;
            end
          end else if (!queue_empty && head_len == 16'd0) begin
            pop = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      row_reg      <= '0;
      len_reg      <= '0;
      buf_base_reg <= '0;
      acc_base_reg <= '0;
      signed_reg   <= 1'b0;
      accum_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (load) begin
        buf_base_reg <= head[23:0];
        acc_base_reg <= head[39:24];
        len_reg      <= head_len;
        signed_reg   <= head[57];
        accum_reg    <= head[56];
        row_reg      <= '0;
      end else if (issue) begin
        row_reg <= row_reg + 16'd1;
      end
    end
  end

  // One shared line; the MMU taps it early, the accumulator at the far end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_valid_reg  <= '0;
      line_first_reg  <= '0;
      line_signed_reg <= '0;
      line_accum_reg  <= '0;
      for (int i = 0; i < LINE_LEN; i++) line_addr_reg[i] <= '0;
    end else if (enable) begin
      line_valid_reg  <= {line_valid_reg[LINE_LEN-2:0], state_reg == ISSUE};
      line_first_reg  <= {line_first_reg[LINE_LEN-2:0], row_reg == 16'd0};
      line_signed_reg <= {line_signed_reg[LINE_LEN-2:0], signed_reg};
      line_accum_reg  <= {line_accum_reg[LINE_LEN-2:0], accum_reg};
      for (int i = LINE_LEN - 1; i > 0; i--) line_addr_reg[i] <= line_addr_reg[i-1];
      line_addr_reg[0] <= acc_base_reg + row_reg;
    end
  end

  assign buffer_read_enable = issue;
  assign buffer_to_sds_addr = buf_base_reg + {8'd0, row_reg};
  assign mmu_sds_enable     = line_valid_reg[MMU_TAP] && enable;
  assign is_mmu_signed      = line_valid_reg[MMU_TAP] && line_signed_reg[MMU_TAP];
  assign activate_weight    = line_valid_reg[MMU_TAP] && line_first_reg[MMU_TAP] && enable;
  assign acc_enable         = line_valid_reg[LINE_LEN-1] && enable;
  assign accumulate         = line_valid_reg[LINE_LEN-1] && line_accum_reg[LINE_LEN-1];
  assign acc_addr           = line_addr_reg[LINE_LEN-1];
  assign resource_busy      = (state_reg == ISSUE);
  assign busy               = !queue_empty || (state_reg == ISSUE) || (|line_valid_reg);
  assign overflow           = overflow_reg;

`ifdef MMU_CTRL_PERF_CNT_EN
  logic [31:0] rows_issued_reg, stall_cycles_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rows_issued_reg  <= '0;
      stall_cycles_reg <= '0;
    end else if (perf_clear) begin
      rows_issued_reg  <= '0;
      stall_cycles_reg <= '0;
    end else begin
      if (issue && rows_issued_reg != 32'hFFFF_FFFF) rows_issued_reg <= rows_issued_reg + 32'd1;
      if (!enable && busy && stall_cycles_reg != 32'hFFFF_FFFF)
        stall_cycles_reg <= stall_cycles_reg + 32'd1;
    end
  end

  assign rows_issued  = rows_issued_reg;
  assign stall_cycles = stall_cycles_reg;
`endif

endmodule

// File: tb/tb_mmu_stream_controller.sv
// Bench for mmu_stream_controller: directed scenarios plus random instructions,
// checked against a row-level scoreboard built from the instruction rules.
module tb_mmu_stream_controller;

  localparam int MATRIX_WIDTH      = 14;
  localparam int BUF_READ_LATENCY  = 1;
  localparam int MMU_EXTRA_LATENCY = 2;
  localparam int INSTR_QUEUE_DEPTH = 4;
  localparam int ACC_DELAY         = BUF_READ_LATENCY + MATRIX_WIDTH + MMU_EXTRA_LATENCY;

  logic        clk = 1'b0;
  logic        rst, enable, instr_enable;
  logic [63:0] instr;
  logic        instr_ready, buffer_read_enable, mmu_sds_enable, is_mmu_signed;
  logic        activate_weight, accumulate, acc_enable, busy, resource_busy, overflow;
  logic [23:0] buffer_to_sds_addr;
  logic [15:0] acc_addr;

  mmu_stream_controller #(
    .MATRIX_WIDTH(MATRIX_WIDTH), .BUF_READ_LATENCY(BUF_READ_LATENCY),
    .MMU_EXTRA_LATENCY(MMU_EXTRA_LATENCY), .INSTR_QUEUE_DEPTH(INSTR_QUEUE_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .instr(instr), .instr_enable(instr_enable),
    .instr_ready(instr_ready), .buffer_to_sds_addr(buffer_to_sds_addr),
    .buffer_read_enable(buffer_read_enable), .mmu_sds_enable(mmu_sds_enable),
    .is_mmu_signed(is_mmu_signed), .activate_weight(activate_weight), .acc_addr(acc_addr),
    .accumulate(accumulate), .acc_enable(acc_enable), .busy(busy),
    .resource_busy(resource_busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] baddr;
    logic [15:0] aaddr;
    logic        sgn;
    logic        acm;
    logic        first;
    int          due;
  } row_t;

  row_t exp_rows[$];
  row_t mmu_pend[$];
  row_t acc_pend[$];
  int   aw_cyc[$];

  int check_count = 0, pass_count = 0, fail_count = 0;
  int cyc = 0, tick = 0;
  int bre_count, acc_count, run_len, max_run;
  int first_bre, last_bre, first_mmu, last_mmu, first_acc, last_acc;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_count++;
    assert (obs === exp) pass_count++;
    else begin
      fail_count++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: rows leave in issue order; MMU and accumulator see each row
  // a fixed number of enabled cycles after its buffer read.
  always @(negedge clk) begin
    row_t r;
    if (rst) begin
      exp_rows.delete();
      mmu_pend.delete();
      acc_pend.delete();
      run_len = 0;
    end else if (!enable) begin
      chk("stall_strobes", {60'd0, buffer_read_enable, mmu_sds_enable, activate_weight, acc_enable}, 64'd0);
    end else begin
      if (buffer_read_enable) begin
        chk("read_has_row", exp_rows.size() != 0, 1);
        if (exp_rows.size() != 0) begin
          r = exp_rows.pop_front();
          chk("buf_addr", buffer_to_sds_addr, r.baddr);
          r.due = tick + BUF_READ_LATENCY;
          mmu_pend.push_back(r);
          r.due = tick + ACC_DELAY;
          acc_pend.push_back(r);
        end
        bre_count++;
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (first_bre < 0) first_bre = cyc;
        last_bre = cyc;
      end else begin
        run_len = 0;
      end
      if (mmu_pend.size() != 0 && mmu_pend[0].due <= tick) begin
        r = mmu_pend.pop_front();
        chk("mmu_enable", mmu_sds_enable, 1);
        chk("mmu_signed", is_mmu_signed, r.sgn);
        chk("activate_weight", activate_weight, r.first);
      end else begin
        chk("mmu_quiet", {mmu_sds_enable, activate_weight}, 0);
      end
      if (mmu_sds_enable) begin
        if (first_mmu < 0) first_mmu = cyc;
        last_mmu = cyc;
      end
      if (activate_weight) aw_cyc.push_back(cyc);
      if (acc_pend.size() != 0 && acc_pend[0].due <= tick) begin
        r = acc_pend.pop_front();
        chk("acc_enable", acc_enable, 1);
        chk("acc_addr", acc_addr, r.aaddr);
        chk("accumulate", accumulate, r.acm);
      end else begin
        chk("acc_quiet", acc_enable, 0);
      end
      if (acc_enable) begin
        acc_count++;
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
      end
      tick++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    bre_count = 0; acc_count = 0; run_len = 0; max_run = 0;
    first_bre = -1; last_bre = -1; first_mmu = -1; last_mmu = -1;
    first_acc = -1; last_acc = -1;
    aw_cyc.delete();
  endtask

  task automatic push_instr(input logic [7:0] op, input logic [15:0] len,
                            input logic [15:0] a, input logic [23:0] b, input bit accept);
    row_t r;
    instr        = {op, len, a, b};
    instr_enable = 1'b1;
    step();
    instr_enable = 1'b0;
    if (accept) begin
      for (int k = 0; k < int'(len); k++) begin
        r.baddr = b + 24'(k);
        r.aaddr = a + 16'(k);
        r.sgn   = op[1];
        r.acm   = op[0];
        r.first = (k == 0);
        r.due   = 0;
        exp_rows.push_back(r);
      end
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    enable = 1'b1;
    while ((busy !== 1'b0 || exp_rows.size() != 0 || acc_pend.size() != 0) && n < 400) begin
      step();
      n++;
    end
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rows_left"}, exp_rows.size() + mmu_pend.size() + acc_pend.size(), 0);
  endtask

  initial begin
    int t0, n;
    logic [23:0] rb;
    rst = 1'b1; enable = 1'b1; instr_enable = 1'b0; instr = '0;
    clear_stats();
    step(); step();
    chk("reset_ready", instr_ready, 1);
    chk("reset_strobes", {buffer_read_enable, mmu_sds_enable, is_mmu_signed, activate_weight,
                          accumulate, acc_enable, busy, resource_busy, overflow}, 0);
    chk("reset_addrs", {buffer_to_sds_addr, acc_addr}, 0);
    rst = 1'b0;
    step();

    // Single length-29 instruction with absolute timing.
    clear_stats();
    push_instr(8'h23, 16'd29, 16'h0049, 24'h009463, 1);
    t0 = cyc;
    repeat (46) step();
    chk("t1_busy_last_acc", busy, 1);
    step();
    chk("t1_busy_after", busy, 0);
    chk("t1_first_read", first_bre, t0 + 1);
    chk("t1_last_read", last_bre, t0 + 29);
    chk("t1_first_mmu", first_mmu, t0 + 2);
    chk("t1_last_mmu", last_mmu, t0 + 30);
    chk("t1_aw_count", aw_cyc.size(), 1);
    if (aw_cyc.size() != 0) chk("t1_aw_cycle", aw_cyc[0], t0 + 2);
    chk("t1_first_acc", first_acc, t0 + 18);
    chk("t1_last_acc", last_acc, t0 + 46);
    chk("t1_acc_count", acc_count, 29);

    // Back-to-back instructions with differing opcodes.
    clear_stats();
    push_instr(8'h20, 16'd14, 16'h0006, 24'h0000AB, 1);
    push_instr(8'h23, 16'd3, 16'h0100, 24'h000200, 1);
    drain("t2");
    chk("t2_read_count", bre_count, 17);
    chk("t2_contiguous", max_run, 17);
    chk("t2_aw_count", aw_cyc.size(), 2);
    if (aw_cyc.size() == 2) chk("t2_aw_spacing", aw_cyc[1] - aw_cyc[0], 14);

    // Empty instruction between two short ones.
    clear_stats();
    push_instr(8'h22, 16'd2, 16'h0010, 24'h000300, 1);
    push_instr(8'h21, 16'd0, 16'h0020, 24'h000400, 1);
    push_instr(8'h20, 16'd2, 16'h0030, 24'h000500, 1);
    drain("t3");
    chk("t3_read_count", bre_count, 4);
    chk("t3_contiguous", max_run, 4);

    // Address wrap.
    clear_stats();
    push_instr(8'h21, 16'd3, 16'hFFFF, 24'hFFFFFF, 1);
    drain("wrap");
    chk("wrap_read_count", bre_count, 3);

    // Queue overflow while the issuer is busy.
    clear_stats();
    push_instr(8'h20, 16'd29, 16'h0200, 24'h010000, 1);
    step(); step();
    for (int i = 0; i < 4; i++) push_instr(8'h21, 16'd2, 16'(16'h0300 + 4 * i), 24'(24'h020000 + 8 * i), 1);
    chk("ovf_ready_full", instr_ready, 0);
    chk("ovf_before", overflow, 0);
    push_instr(8'h23, 16'd2, 16'h0700, 24'h030000, 0);
    chk("ovf_set", overflow, 1);
    drain("ovf");
    chk("ovf_sticky", overflow, 1);
    chk("ovf_read_count", bre_count, 37);

    // Stall for 5 cycles at row 10.
    clear_stats();
    push_instr(8'h21, 16'd29, 16'h1000, 24'h00A000, 1);
    n = 0;
    while (bre_count < 10 && n < 100) begin step(); n++; end
    enable = 1'b0;
    chk("stall_addr_row10", buffer_to_sds_addr, 24'h00A00A);
    repeat (5) step();
    chk("stall_addr_hold", buffer_to_sds_addr, 24'h00A00A);
    chk("stall_resource_busy", resource_busy, 1);
    enable = 1'b1;
    drain("stall");
    chk("stall_read_count", bre_count, 29);
    chk("stall_acc_count", acc_count, 29);

    // Reset mid-instruction.
    clear_stats();
    push_instr(8'h23, 16'd29, 16'h0300, 24'h001000, 1);
    n = 0;
    while (bre_count < 7 && n < 100) begin step(); n++; end
    rst = 1'b1;
    #1;
    chk("rst_strobes", {buffer_read_enable, mmu_sds_enable, activate_weight, acc_enable,
                        busy, resource_busy, overflow}, 0);
    chk("rst_ready", instr_ready, 1);
    step(); step();
    rst = 1'b0;
    step();
    clear_stats();
    push_instr(8'h22, 16'd3, 16'h0400, 24'h002000, 1);
    t0 = cyc;
    drain("rst");
    chk("rst_restart_cycle", first_bre, t0 + 1);
    chk("rst_read_count", bre_count, 3);

    // Random instructions with random enable drops.
    clear_stats();
    for (int i = 0; i < 40; i++) begin
      enable = 1'b1;
      n = 0;
      while (instr_ready !== 1'b1 && n < 200) begin step(); n++; end
      rb = ($urandom_range(0, 3) == 0) ? 24'(24'hFFFFFC + $urandom_range(0, 3)) : 24'($urandom);
      push_instr(8'($urandom_range(0, 255)), 16'($urandom_range(0, 6)), 16'($urandom), rb, 1);
      repeat ($urandom_range(0, 3)) begin
        enable = ($urandom_range(0, 3) != 0);
        step();
      end
    end
    drain("rand");

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
